fxp_block_accumulator: RTL and testbench
========================================

FXP_BLOCK_ACCUMULATOR -- requirements
Module: fxp_block_accumulator

Interface
REQ-001 The block SHALL have parameter WII, default 8: integer bits of input and output fixed-point, two's complement.
REQ-002 The block SHALL have parameter WIF, default 8: fractional bits of input and output.
REQ-003 The block SHALL have parameter N, default 4: samples summed per block, legal range 2..256.
REQ-004 The block SHALL have parameter bit ROOF, default 1: 1 saturates the output to the signed range, 0 wraps it.
REQ-005 rstn  input  1  synchronous active-low reset.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 i_clear  input  1  discard the partial sum.
REQ-008 i_valid  input  1  upstream sample valid.
REQ-009 i_ready  output  1  block accepts a sample this cycle.
REQ-010 i_data  input  WII+WIF  fixed-point sample.
REQ-011 o_valid  output  1  block sum available.
REQ-012 o_ready  input  1  downstream (fixed-to-float32 converter stage) accepts the sum.
REQ-013 o_data  output  WII+WIF  fixed-point block sum, same format as i_data.
REQ-014 o_upflow  output  1  the sum clipped or wrapped positive; qualified by o_valid.
REQ-015 o_downflow  output  1  the sum clipped or wrapped negative; qualified by o_valid.

Function
REQ-016 States SHALL be ACC and HOLD; i_ready SHALL be 1 exactly when in ACC.
REQ-017 A sample SHALL be accepted on a cycle with i_valid && i_ready && !i_clear.
REQ-018 Each accepted sample SHALL be sign-extended and added into an internal accumulator of width WII+WIF+$clog2(N)+1; this accumulator SHALL never overflow.
REQ-019 A sample counter (0..N-1) SHALL increment on every accept.
REQ-020 On the N-th accept the block SHALL: load o_data and the flags from (accumulator + sample), clear the accumulator and counter, and enter HOLD; o_valid SHALL be 1 on the next cycle (latency 1 cycle from the last accept).
REQ-021 Saturation, ROOF=1: a full sum > 2^(WII+WIF-1)-1 SHALL give o_data 0111..1 with o_upflow=1; a full sum < -2^(WII+WIF-1) SHALL give o_data 100..0 with o_downflow=1.
REQ-022 Wrap, ROOF=0: o_data SHALL be the low WII+WIF bits of the full sum; the flags SHALL be set under the same conditions as with ROOF=1.
REQ-023 The flags SHALL never both be 1.
REQ-024 In HOLD, o_valid, o_data and the flags SHALL stay stable until a cycle with o_ready=1; that cycle SHALL return the block to ACC with o_valid=0 on the next cycle.
REQ-025 No bypass: a sample SHALL NOT be accepted in the same cycle as the HOLD-to-ACC handshake. Peak throughput is N samples per N+1 cycles.
REQ-026 i_clear in ACC SHALL zero the accumulator and counter; any i_valid sample in that cycle SHALL be dropped.
REQ-027 i_clear in HOLD SHALL be ignored; the pending output SHALL not be lost.
REQ-028 o_ready while in ACC SHALL have no effect.
REQ-029 A sum of exactly zero SHALL produce o_data 0 with both flags 0.

Reset
REQ-030 On a clock edge with rstn=0, the block SHALL enter ACC and zero the accumulator, counter, o_data, o_valid, o_upflow and o_downflow; i_ready SHALL be 1 on the following cycle.
REQ-031 Reset during ACC with a partial sum, or during HOLD with an undelivered sum, SHALL discard that data.

Structure
REQ-032 The state enum {ACC, HOLD} SHALL reside in shared package fxp_pkg, together with the accumulator-width helper constant expression.
REQ-033 Saturation/wrap SHALL be a combinational sub-module, comb_FixedPointSat (parameters WIN, WOUT, ROOF; outputs value, upflow, downflow), instantiated once.
REQ-034 The implementation SHALL have one sequential always block plus a combinational next-sum.

Verification
Unless stated otherwise, benches use WII=8, WIF=8, N=4, ROOF=1.
REQ-035 Four samples of 0x0100 (+1.0), o_ready held 1 -> o_data=0x0400, both flags 0, o_valid 1 cycle after the 4th accept, then i_ready=1.
REQ-036 Four samples of 0x7FFF -> o_data=0x7FFF, o_upflow=1. Repeat with ROOF=0 -> o_data=0xFFFC, o_upflow=1.
REQ-037 Four samples of 0x8000 -> o_data=0x8000, o_downflow=1.
REQ-038 Mixed 0x0300, 0xFE00, 0x0080, 0xFF80 -> o_data=0x0100, flags 0.
REQ-039 Back-pressure: o_ready=0 for 5 cycles after o_valid -> o_data stable and i_ready=0 throughout, i_clear pulsed in HOLD is ignored, i_valid in the handshake cycle is not accepted.
REQ-040 Two samples of 0x0100, then i_clear, then four samples of 0x0200 -> o_data=0x0800. Separately, rstn=0 mid-block -> all outputs 0 and the next block sums only post-reset samples.

Source files
------------

// File: rtl/fxp_pkg.sv
// Shared types and width helpers for the fixed-point block accumulator.
package fxp_pkg;

    typedef enum logic {ACC, HOLD} acc_state_e;

    // Accumulator width that can hold n full-scale w-bit samples without overflow.
    function automatic int unsigned acc_width(input int unsigned w, input int unsigned n);
        return w + $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/comb_FixedPointSat.sv
// Narrows a signed WIN-bit value to WOUT bits, saturating (ROOF=1) or wrapping (ROOF=0).
module comb_FixedPointSat #(
    parameter int unsigned WIN  = 19,
    parameter int unsigned WOUT = 16,
    parameter bit          ROOF = 1'b1
) (
    input  logic [WIN-1:0]  in,
    output logic [WOUT-1:0] value,
    output logic            upflow,
    output logic            downflow
);

    // Bits that must all equal the sign bit for the value to fit in WOUT bits.
    logic [WIN-WOUT:0] top;

    always_comb begin
        top      = in[WIN-1:WOUT-1];
        upflow   = !in[WIN-1] && (top != '0);
        downflow = in[WIN-1] && (top != '1);
        value    = in[WOUT-1:0];
        if (ROOF) begin
            if (upflow) begin
                value = {1'b0, {(WOUT-1){1'b1}}};
            end else if (downflow) begin
                value = {1'b1, {(WOUT-1){1'b0}}};
            end
        end
    end

endmodule

// File: rtl/fxp_block_accumulator.sv
// Sums blocks of N fixed-point samples and presents each block sum with overflow flags.
module fxp_block_accumulator
    import fxp_pkg::*;
#(
    parameter int unsigned WII  = 8,
    parameter int unsigned WIF  = 8,
    parameter int unsigned N    = 4,
    parameter bit          ROOF = 1'b1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               i_clear,
    input  logic               i_valid,
    output logic               i_ready,
    input  logic [WII+WIF-1:0] i_data,
    output logic               o_valid,
    input  logic               o_ready,
    output logic [WII+WIF-1:0] o_data,
    output logic               o_upflow,
    output logic               o_downflow
);

    localparam int unsigned W  = WII + WIF;
    localparam int unsigned AW = acc_width(W, N);
    localparam int unsigned CW = $clog2(N);

    acc_state_e      state_q;
    logic [AW-1:0]   acc_q;
    logic [CW-1:0]   cnt_q;

    logic [AW-1:0]   sum_next;
    logic            accept;
    logic            last;
    logic [W-1:0]    sat_value;
    logic            sat_up;
    logic            sat_down;

    assign i_ready = (state_q == ACC);

    always_comb begin
        accept   = i_valid && (state_q == ACC) && !i_clear;
        last     = (cnt_q == CW'(N - 1));
        sum_next = acc_q + {{(AW-W){i_data[W-1]}}, i_data};
    end

    comb_FixedPointSat #(
        .WIN  (AW),
        .WOUT (W),
        .ROOF (ROOF)
    ) u_sat (
        .in       (sum_next),
        .value    (sat_value),
        .upflow   (sat_up),
        .downflow (sat_down)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ACC;
            acc_q      <= '0;
            cnt_q      <= '0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_upflow   <= 1'b0;
            o_downflow <= 1'b0;
        end else begin
            unique case (state_q)
                ACC: begin
                    if (i_clear) begin
                        acc_q <= '0;
                        cnt_q <= '0;
                    end else if (accept) begin
                        if (last) begin
                            o_data     <= sat_value;
                            o_upflow   <= sat_up;
                            o_downflow <= sat_down;
                            o_valid    <= 1'b1;
                            acc_q      <= '0;
                            cnt_q      <= '0;
                            state_q    <= HOLD;
                        end else begin
                            acc_q <= sum_next;
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                HOLD: begin
                    // No bypass: the handshake cycle never accepts a sample.
                    if (o_ready) begin
                        o_valid <= 1'b0;
                        state_q <= ACC;
                    end
                end
                default: state_q <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_fxp_block_accumulator.sv
// Directed scoreboard bench for fxp_block_accumulator (saturating and wrapping instances).
module tb_fxp_block_accumulator;

    logic        clk = 1'b0;
    logic        rstn;
    logic        i_clear;
    logic        i_valid;
    logic [15:0] i_data;
    logic        o_ready;

    logic        s_i_ready, s_o_valid, s_up, s_dn;
    logic [15:0] s_o_data;
    logic        w_i_ready, w_o_valid, w_up, w_dn;
    logic [15:0] w_o_data;

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    typedef struct {
        logic [15:0] d;
        logic [15:0] dw;
        logic        up;
        logic        dn;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    fxp_block_accumulator #(.WII(8), .WIF(8), .N(4), .ROOF(1'b1)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .i_clear    (i_clear),
        .i_valid    (i_valid),
        .i_ready    (s_i_ready),
        .i_data     (i_data),
        .o_valid    (s_o_valid),
        .o_ready    (o_ready),
        .o_data     (s_o_data),
        .o_upflow   (s_up),
        .o_downflow (s_dn)
    );

    fxp_block_accumulator #(.WII(8), .WIF(8), .N(4), .ROOF(1'b0)) dut_wrap (
        .clk        (clk),
        .rstn       (rstn),
        .i_clear    (i_clear),
        .i_valid    (i_valid),
        .i_ready    (w_i_ready),
        .i_data     (i_data),
        .o_valid    (w_o_valid),
        .o_ready    (o_ready),
        .o_data     (w_o_data),
        .o_upflow   (w_up),
        .o_downflow (w_dn)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sample(input logic [15:0] d);
        int waited = 0;
        i_valid = 1'b1;
        i_data  = d;
        while (!s_i_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!s_i_ready) check("ready_timeout", 32'(s_i_ready), 32'd1);
        tick();
        i_valid = 1'b0;
    endtask

    function automatic exp_t model(input logic [3:0][15:0] s);
        exp_t e;
        int   sum = 0;
        for (int i = 0; i < 4; i++) sum += int'($signed(s[i]));
        e.dw = sum[15:0];
        e.up = (sum > 32767);
        e.dn = (sum < -32768);
        e.d  = e.up ? 16'h7FFF : (e.dn ? 16'h8000 : sum[15:0]);
        return e;
    endfunction

    task automatic run_block(input string tag, input logic [3:0][15:0] s, input int stall);
        exp_t e;
        sb.push_back(model(s));
        o_ready = (stall == 0);
        for (int i = 0; i < 4; i++) send_sample(s[i]);
        check({tag, "_valid"}, 32'(s_o_valid), 32'd1);
        e = sb.pop_front();
        check({tag, "_data"}, 32'(s_o_data), 32'(e.d));
        check({tag, "_up"}, 32'(s_up), 32'(e.up));
        check({tag, "_down"}, 32'(s_dn), 32'(e.dn));
        check({tag, "_wrap_data"}, 32'(w_o_data), 32'(e.dw));
        check({tag, "_wrap_flags"}, {30'd0, w_up, w_dn}, {30'd0, e.up, e.dn});
        for (int k = 0; k < stall; k++) begin
            check({tag, "_hold_data"}, 32'(s_o_data), 32'(e.d));
            check({tag, "_hold_ready"}, 32'(s_i_ready), 32'd0);
            check({tag, "_hold_valid"}, 32'(s_o_valid), 32'd1);
            i_clear = (k == 2);
            tick();
            i_clear = 1'b0;
        end
        // Sample offered in the handshake cycle must be dropped.
        o_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = 16'h7000;
        tick();
        i_valid = 1'b0;
        check({tag, "_done_valid"}, 32'(s_o_valid), 32'd0);
        check({tag, "_done_ready"}, 32'(s_i_ready), 32'd1);
    endtask

    initial begin
        rstn    = 1'b0;
        i_clear = 1'b0;
        i_valid = 1'b0;
        i_data  = '0;
        o_ready = 1'b0;
        tick();
        tick();
        check("rst_valid", 32'(s_o_valid), 32'd0);
        check("rst_data", 32'(s_o_data), 32'd0);
        check("rst_flags", {30'd0, s_up, s_dn}, 32'd0);
        check("rst_ready", 32'(s_i_ready), 32'd1);
        rstn = 1'b1;
        tick();

        run_block("ones", {16'h0100, 16'h0100, 16'h0100, 16'h0100}, 0);
        run_block("posmax", {16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF}, 0);
        run_block("negmax", {16'h8000, 16'h8000, 16'h8000, 16'h8000}, 0);
        run_block("mixed", {16'hFF80, 16'h0080, 16'hFE00, 16'h0300}, 0);
        run_block("zero", {16'hFF00, 16'h0100, 16'hFE00, 16'h0200}, 0);
        run_block("stall", {16'h0040, 16'h0040, 16'h0040, 16'h0040}, 5);

        // Partial sum discarded by i_clear; the sample in the clear cycle is dropped too.
        send_sample(16'h0100);
        send_sample(16'h0100);
        i_clear = 1'b1;
        i_valid = 1'b1;
        i_data  = 16'h0100;
        tick();
        i_clear = 1'b0;
        i_valid = 1'b0;
        check("clear_ready", 32'(s_i_ready), 32'd1);
        run_block("after_clear", {16'h0200, 16'h0200, 16'h0200, 16'h0200}, 0);

        // Reset mid-block.
        send_sample(16'h0100);
        send_sample(16'h0100);
        rstn = 1'b0;
        tick();
        check("midrst_valid", 32'(s_o_valid), 32'd0);
        check("midrst_data", 32'(s_o_data), 32'd0);
        rstn = 1'b1;
        run_block("after_rst", {16'h0100, 16'h0100, 16'h0100, 16'h0100}, 0);

        // Reset while holding an undelivered sum.
        o_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_sample(16'h0100);
        check("hold_valid", 32'(s_o_valid), 32'd1);
        rstn = 1'b0;
        tick();
        check("holdrst_valid", 32'(s_o_valid), 32'd0);
        check("holdrst_data", 32'(s_o_data), 32'd0);
        check("holdrst_ready", 32'(s_i_ready), 32'd1);
        rstn = 1'b1;
        run_block("post_hold_rst", {16'h0300, 16'h0000, 16'h0000, 16'h0000}, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
